// File: rtl/fir_sample_pacer_if.sv
// Producer-to-pacer sample stream: signed samples over a valid/ready handshake.
interface fir_sample_pacer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fir_sample_pacer.sv
// Buffers producer samples and releases one per FIR accumulate period on a stable output.
// Optional saturating underflow counter port: define FIR_PACER_UNDERFLOW_CNT_EN.
module fir_sample_pacer #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  parameter  int PERIOD = 20,
  parameter  int PRIME  = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1,
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  fir_sample_pacer_if.slave   s_if,
  input  logic                enable,
  output logic [DATA_W-1:0]   sample_out,
  output logic                fir_ready,
  output logic                sample_strobe,
  output logic [LW-1:0]       level,
  output logic                underflow
`ifdef FIR_PACER_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]          underflow_cnt
`endif
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              fir_ready_q, fir_ready_d;
  logic              strobe_q, strobe_d;
  logic              underflow_q, underflow_d;
  logic              push, pop, uf_evt;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot early.
  assign s_if.s_ready = (level_q != LW'(DEPTH));
  assign push         = s_if.s_valid && s_if.s_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    strobe_d = 1'b0;
    pop      = 1'b0;
    uf_evt   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && (level_q >= LW'(PRIME))) begin
          pop      = 1'b1;
          sample_d = mem_q[rd_ptr_q];
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(PERIOD - 1)) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          if (level_q != '0) begin
            pop      = 1'b1;
            sample_d = mem_q[rd_ptr_q];
          end else begin
            sample_d = '0;
            uf_evt   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fir_ready_d = (state_d == ST_RUN);
    underflow_d = underflow_q | uf_evt;
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    level_d     = level_q + LW'(push) - LW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      fir_ready_q <= 1'b0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      fir_ready_q <= fir_ready_d;
      strobe_q    <= strobe_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and level is what discards its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_if.s_data;
    end
  end

`ifdef FIR_PACER_UNDERFLOW_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (uf_evt && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_cnt = ucnt_q;
`endif

  assign sample_out    = sample_q;
  assign fir_ready     = fir_ready_q;
  assign sample_strobe = strobe_q;
  assign level         = level_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_fir_sample_pacer.sv
// Directed self-checking bench for fir_sample_pacer; inputs change and outputs are sampled 1ns after each rising edge.
module tb_fir_sample_pacer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int PERIOD = 20;
  localparam int PRIME  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] sample_out;
  logic       fir_ready;
  logic       sample_strobe;
  logic [3:0] level;
  logic       underflow;
`ifdef FIR_PACER_UNDERFLOW_CNT_EN
  logic [7:0] underflow_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fir_sample_pacer_if #(.DATA_W(DATA_W)) src ();

  fir_sample_pacer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PERIOD(PERIOD), .PRIME(PRIME)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_if          (src),
    .enable        (enable),
    .sample_out    (sample_out),
    .fir_ready     (fir_ready),
    .sample_strobe (sample_strobe),
    .level         (level),
    .underflow     (underflow)
`ifdef FIR_PACER_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt (underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n, output int strobes);
    strobes = 0;
    repeat (n) begin
      tick();
      if (sample_strobe) strobes++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; src.s_valid = 1'b0; src.s_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; src.s_valid = 1'b1; src.s_data = 8'h5A;
    tick(); tick();
    n_cmp++; if (sample_out !== 8'h00) begin n_err++; $display("FAIL reset.sample_out got=%h exp=00", sample_out); end
    n_cmp++; if (fir_ready !== 1'b0) begin n_err++; $display("FAIL reset.fir_ready got=%b exp=0", fir_ready); end
    n_cmp++; if (sample_strobe !== 1'b0) begin n_err++; $display("FAIL reset.strobe got=%b exp=0", sample_strobe); end
    n_cmp++; if (src.s_ready !== 1'b1) begin n_err++; $display("FAIL reset.s_ready got=%b exp=1", src.s_ready); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset.level got=%0d exp=0", level); end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset.underflow got=%b exp=0", underflow); end
`ifdef FIR_PACER_UNDERFLOW_CNT_EN
    n_cmp++; if (underflow_cnt !== 8'd0) begin n_err++; $display("FAIL reset.underflow_cnt got=%0d exp=0", underflow_cnt); end
`endif
    rst = 1'b0; src.s_valid = 1'b0; enable = 1'b0;
    tick();
  endtask

  task automatic test_prime_start();
    int s;
    do_reset();
    enable = 1'b1; src.s_valid = 1'b1; src.s_data = 8'h05;
    tick();
    n_cmp++; if (fir_ready !== 1'b0 || level !== 4'd1) begin n_err++; $display("FAIL prime.lvl1 fir_ready=%b level=%0d exp 0/1", fir_ready, level); end
    src.s_data = 8'h7F;
    tick();
    n_cmp++; if (fir_ready !== 1'b0 || level !== 4'd2) begin n_err++; $display("FAIL prime.lvl2 fir_ready=%b level=%0d exp 0/2", fir_ready, level); end
    src.s_data = 8'h80;
    tick();
    src.s_valid = 1'b0;
    n_cmp++; if (sample_out !== 8'h05 || fir_ready !== 1'b1 || sample_strobe !== 1'b1) begin
      n_err++; $display("FAIL prime.entry sample=%h rdy=%b stb=%b exp 05/1/1", sample_out, fir_ready, sample_strobe); end
    n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL prime.entry_level got=%0d exp=2", level); end
    tick_n(PERIOD - 1, s);
    n_cmp++; if (s !== 0 || sample_out !== 8'h05) begin n_err++; $display("FAIL prime.hold1 strobes=%0d sample=%h exp 0/05", s, sample_out); end
    tick();
    n_cmp++; if (sample_strobe !== 1'b1 || sample_out !== 8'h7F || level !== 4'd1) begin
      n_err++; $display("FAIL prime.second stb=%b sample=%h level=%0d exp 1/7f/1", sample_strobe, sample_out, level); end
    tick_n(PERIOD - 1, s);
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL prime.hold2 strobes=%0d exp=0", s); end
    tick();
    n_cmp++; if (sample_strobe !== 1'b1 || sample_out !== 8'h80 || level !== 4'd0) begin
      n_err++; $display("FAIL prime.third stb=%b sample=%h level=%0d exp 1/80/0", sample_strobe, sample_out, level); end
  endtask

  task automatic test_underflow();
    int s;
    do_reset();
    enable = 1'b1; src.s_valid = 1'b1; src.s_data = 8'h3C;
    tick();
    src.s_data = 8'hC3;
    tick();
    src.s_valid = 1'b0;
    tick();
    n_cmp++; if (sample_out !== 8'h3C || underflow !== 1'b0) begin n_err++; $display("FAIL uf.first sample=%h uf=%b exp 3c/0", sample_out, underflow); end
    tick_n(PERIOD - 1, s);
    tick();
    n_cmp++; if (sample_out !== 8'hC3 || underflow !== 1'b0) begin n_err++; $display("FAIL uf.second sample=%h uf=%b exp c3/0", sample_out, underflow); end
    for (int k = 1; k <= 3; k++) begin
      tick_n(PERIOD - 1, s);
      tick();
      n_cmp++; if (sample_strobe !== 1'b1 || sample_out !== 8'h00 || underflow !== 1'b1 || fir_ready !== 1'b1) begin
        n_err++; $display("FAIL uf.boundary%0d stb=%b sample=%h uf=%b rdy=%b exp 1/00/1/1", k, sample_strobe, sample_out, underflow, fir_ready); end
`ifdef FIR_PACER_UNDERFLOW_CNT_EN
      n_cmp++; if (underflow_cnt !== 8'(k)) begin n_err++; $display("FAIL uf.cnt%0d got=%0d exp=%0d", k, underflow_cnt, k); end
`endif
    end
    enable = 1'b0;
    tick();
    n_cmp++; if (fir_ready !== 1'b0 || underflow !== 1'b1) begin n_err++; $display("FAIL uf.sticky rdy=%b uf=%b exp 0/1", fir_ready, underflow); end
  endtask

  // Continues from the sticky-underflow state left by test_underflow.
  task automatic test_mid_run_reset();
    int s;
    src.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src.s_data = 8'h40 + 8'(i);
      tick();
    end
    src.s_valid = 1'b0; enable = 1'b1;
    tick();
    tick_n(12, s);
    n_cmp++; if (level !== 4'd4 || sample_out !== 8'h40 || fir_ready !== 1'b1 || underflow !== 1'b1) begin
      n_err++; $display("FAIL mrst.pre level=%0d sample=%h rdy=%b uf=%b exp 4/40/1/1", level, sample_out, fir_ready, underflow); end
    rst = 1'b1;
    tick();
    n_cmp++; if (level !== 4'd0 || sample_out !== 8'h00 || fir_ready !== 1'b0 || sample_strobe !== 1'b0 || underflow !== 1'b0 || src.s_ready !== 1'b1) begin
      n_err++; $display("FAIL mrst.post level=%0d sample=%h rdy=%b stb=%b uf=%b srdy=%b exp 0/00/0/0/0/1",
                        level, sample_out, fir_ready, sample_strobe, underflow, src.s_ready); end
`ifdef FIR_PACER_UNDERFLOW_CNT_EN
    n_cmp++; if (underflow_cnt !== 8'd0) begin n_err++; $display("FAIL mrst.cnt got=%0d exp=0", underflow_cnt); end
`endif
    rst = 1'b0;
    tick();
    n_cmp++; if (fir_ready !== 1'b0 || sample_strobe !== 1'b0) begin n_err++; $display("FAIL mrst.idle rdy=%b stb=%b exp 0/0", fir_ready, sample_strobe); end
  endtask

  task automatic test_full_fifo();
    int s;
    int acc;
    do_reset();
    acc = 0;
    src.s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      src.s_data = 8'h10 + 8'(i);
      if (src.s_ready) acc++;
      tick();
    end
    n_cmp++; if (acc !== 8) begin n_err++; $display("FAIL full.accepted got=%0d exp=8", acc); end
    n_cmp++; if (level !== 4'd8 || src.s_ready !== 1'b0) begin n_err++; $display("FAIL full.level level=%0d srdy=%b exp 8/0", level, src.s_ready); end
    src.s_data = 8'h99; enable = 1'b1;
    tick();
    src.s_valid = 1'b0;
    n_cmp++; if (level !== 4'd7 || src.s_ready !== 1'b1) begin n_err++; $display("FAIL full.pop level=%0d srdy=%b exp 7/1", level, src.s_ready); end
    n_cmp++; if (sample_out !== 8'h10 || fir_ready !== 1'b1) begin n_err++; $display("FAIL full.head sample=%h rdy=%b exp 10/1", sample_out, fir_ready); end
    tick_n(PERIOD - 1, s);
    tick();
    n_cmp++; if (sample_out !== 8'h11 || level !== 4'd6) begin n_err++; $display("FAIL full.next sample=%h level=%0d exp 11/6", sample_out, level); end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [7:0] vec [13];
    vec = '{8'h01, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h12, 8'hED, 8'h33, 8'hC4, 8'h6B, 8'h9E};
    do_reset();
    src.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src.s_data = vec[i];
      tick();
    end
    src.s_valid = 1'b0;
    n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL b2b.preload level=%0d exp=3", level); end
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      src.s_valid = 1'b1; src.s_data = vec[k + 3];
      tick();
      src.s_valid = 1'b0;
      n_cmp++; if (sample_strobe !== 1'b1 || sample_out !== vec[k] || level !== 4'd3) begin
        n_err++; $display("FAIL b2b.sample%0d stb=%b sample=%h level=%0d exp 1/%h/3", k, sample_strobe, sample_out, level, vec[k]); end
      if (k < 9) begin
        tick_n(PERIOD - 1, s);
        n_cmp++; if (s !== 0) begin n_err++; $display("FAIL b2b.gap%0d strobes=%0d exp=0", k, s); end
      end
    end
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL b2b.underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_enable_drop();
    int s;
    do_reset();
    enable = 1'b1; src.s_valid = 1'b1;
    src.s_data = 8'h21; tick();
    src.s_data = 8'h22; tick();
    src.s_data = 8'h23; tick();
    src.s_valid = 1'b0;
    tick_n(7, s);
    enable = 1'b0;
    tick();
    n_cmp++; if (fir_ready !== 1'b0 || sample_out !== 8'h21 || level !== 4'd2 || sample_strobe !== 1'b0) begin
      n_err++; $display("FAIL drop.stop rdy=%b sample=%h level=%0d stb=%b exp 0/21/2/0", fir_ready, sample_out, level, sample_strobe); end
    tick_n(5, s);
    n_cmp++; if (s !== 0 || fir_ready !== 1'b0 || sample_out !== 8'h21 || level !== 4'd2) begin
      n_err++; $display("FAIL drop.idle strobes=%0d rdy=%b sample=%h level=%0d exp 0/0/21/2", s, fir_ready, sample_out, level); end
    enable = 1'b1;
    tick();
    n_cmp++; if (sample_strobe !== 1'b1 || sample_out !== 8'h22 || fir_ready !== 1'b1 || level !== 4'd1) begin
      n_err++; $display("FAIL drop.restart stb=%b sample=%h rdy=%b level=%0d exp 1/22/1/1", sample_strobe, sample_out, fir_ready, level); end
    tick_n(PERIOD - 1, s);
    n_cmp++; if (s !== 0) begin n_err++; $display("FAIL drop.period strobes=%0d exp=0", s); end
    tick();
    n_cmp++; if (sample_strobe !== 1'b1 || sample_out !== 8'h23 || level !== 4'd0) begin
      n_err++; $display("FAIL drop.next stb=%b sample=%h level=%0d exp 1/23/0", sample_strobe, sample_out, level); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; src.s_valid = 1'b0; src.s_data = '0;
    test_reset();
    test_prime_start();
    test_underflow();
    test_mid_run_reset();
    test_full_fifo();
    test_back_to_back();
    test_enable_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
